// File: rtl/wb8_interconnect.sv
// rtl/wb8_interconnect.sv - table-driven 8-bit pipelined Wishbone address decoder/router
//
// Purpose:
//    Routes one master (spu32 CPU) to NSLAVES slaves using a base/mask table.
//    Slave i matches when (adr & MASK_i) == (BASE_i & MASK_i); the lowest
//    matching index wins and DEFAULT_SLAVE is used when nothing matches.
//    One transfer may be outstanding; a watchdog terminates transfers that no
//    slave acknowledges within TIMEOUT cycles with an error ack.
//
// Ports:
//    I_wb_clk     system clock
//    I_reset      synchronous active-high reset
//    I_m_adr      master address
//    I_m_cyc      master cycle
//    I_m_stb      master strobe
//    O_m_dat      read data to master
//    O_m_ack      ack to master
//    O_m_stall    stall to master
//    O_m_err      one-cycle pulse accompanying a timeout ack
//    O_s_stb      per-slave strobes
//    I_s_dat      slave read data, slave i at [8*i+:8]
//    I_s_ack      slave acks
//    I_s_stall    slave stalls
//    O_err_adr    last timed-out address (error log build only, else 0)
//    O_err_count  saturating timeout count (error log build only, else 0)
//
// Build option:
//    WB8_IC_ERRLOG_EN  enables capture of O_err_adr / O_err_count.

module wb8_interconnect #(
   parameter int                    NSLAVES       = 4,
   parameter logic [32*NSLAVES-1:0] SLAVE_BASE    = {32'hFFFFFFF0, 32'hFFFFF800, 32'hFFFFF000, 32'h00000000},
   parameter logic [32*NSLAVES-1:0] SLAVE_MASK    = {32'hFFFFFFF0, 32'hFFFFFF00, 32'hFFFFF800, 32'h00000000},
   parameter int                    DEFAULT_SLAVE = 0,
   parameter int                    TIMEOUT       = 255,
   parameter logic [7:0]            ERR_DATA      = 8'hFF
) (
   input  logic                   I_wb_clk,
   input  logic                   I_reset,
   input  logic [31:0]            I_m_adr,
   input  logic                   I_m_cyc,
   input  logic                   I_m_stb,
   output logic [7:0]             O_m_dat,
   output logic                   O_m_ack,
   output logic                   O_m_stall,
   output logic                   O_m_err,
   output logic [NSLAVES-1:0]     O_s_stb,
   input  logic [8*NSLAVES-1:0]   I_s_dat,
   input  logic [NSLAVES-1:0]     I_s_ack,
   input  logic [NSLAVES-1:0]     I_s_stall,
   output logic [31:0]            O_err_adr,
   output logic [7:0]             O_err_count
);

   localparam int SW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic {ST_IDLE, ST_BUSY} state_t;

   state_t        state, state_nxt;
   logic [SW-1:0] sel;
   logic [SW-1:0] sel_q;
   logic [SW-1:0] cur;
   logic [CW-1:0] cnt;
   logic          req;
   logic          accept;

   // Walk the table from the highest index down so the lowest match wins.
   always_comb begin
      sel = SW'(DEFAULT_SLAVE);
      for (int i = NSLAVES - 1; i >= 0; i--) begin
         if ((I_m_adr & SLAVE_MASK[32*i +: 32]) == (SLAVE_BASE[32*i +: 32] & SLAVE_MASK[32*i +: 32]))
            sel = SW'(i);
      end
   end

   assign req = I_m_stb & I_m_cyc;
   assign cur = (state == ST_BUSY) ? sel_q : sel;

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      O_s_stb   = '0;
      O_m_stall = 1'b0;
      O_m_ack   = 1'b0;
      O_m_err   = 1'b0;
      O_m_dat   = I_s_dat[{cur, 3'b000} +: 8];
      case (state)
         ST_IDLE: begin
            O_s_stb[sel] = req;
            O_m_stall    = I_s_stall[sel];
            accept       = req & ~I_s_stall[sel];
            // A same-cycle ack completes the transfer without entering BUSY.
            if (accept) begin
               O_m_ack = I_s_ack[sel];
               if (!I_s_ack[sel])
                  state_nxt = ST_BUSY;
            end
         end
         ST_BUSY: begin
            O_m_stall = 1'b1;
            if (!I_m_cyc) begin
               state_nxt = ST_IDLE;
            end else if (cnt == CW'(TIMEOUT)) begin
               O_m_ack   = 1'b1;
               O_m_err   = 1'b1;
               O_m_dat   = ERR_DATA;
               state_nxt = ST_IDLE;
            end else if (I_s_ack[sel_q]) begin
               O_m_ack   = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      // Outputs hold their reset values while reset is asserted, so a
      // pending slave ack can never leak through.
      if (I_reset) begin
         O_s_stb = '0;
         O_m_ack = 1'b0;
         O_m_err = 1'b0;
         O_m_dat = '0;
      end
   end

   always_ff @(posedge I_wb_clk) begin
      if (I_reset) begin
         state <= ST_IDLE;
         sel_q <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            sel_q <= sel;
            cnt   <= '0;
         end else if (state == ST_BUSY && cnt != CW'(TIMEOUT)) begin
            cnt <= cnt + CW'(1);
         end
      end
   end

`ifdef WB8_IC_ERRLOG_EN
   logic [31:0] adr_q;

   always_ff @(posedge I_wb_clk) begin
      if (I_reset) begin
         adr_q       <= '0;
         O_err_adr   <= '0;
         O_err_count <= '0;
      end else begin
         if (accept)
            adr_q <= I_m_adr;
         if (O_m_err) begin
            O_err_adr <= adr_q;
            if (O_err_count != 8'hFF)
               O_err_count <= O_err_count + 8'd1;
         end
      end
   end
`else
   assign O_err_adr   = '0;
   assign O_err_count = '0;
`endif

endmodule
